// File: rtl/regwr_scoreboard_if.sv
// regwr_scoreboard_if: writeback/issue/operand-check bundle between issue logic and the scoreboard
interface regwr_scoreboard_if #(
   parameter int ADDR_W = 5
);
   localparam int NREG = 2**ADDR_W;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              iss_valid;
   logic [ADDR_W-1:0] iss_addr;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [NREG-1:0]   wr_onehot;
   logic [NREG-1:0]   busy;
   logic              hazard_a;
   logic              hazard_b;
   logic [ADDR_W:0]   pend_cnt;
   logic              all_idle;
   modport master (
      output wr_en, wr_addr, iss_valid, iss_addr, rd_addr_a, rd_addr_b,
      input  wr_onehot, busy, hazard_a, hazard_b, pend_cnt, all_idle
   );
   modport slave (
      input  wr_en, wr_addr, iss_valid, iss_addr, rd_addr_a, rd_addr_b,
      output wr_onehot, busy, hazard_a, hazard_b, pend_cnt, all_idle
   );
endinterface

// File: rtl/regwr_scoreboard.sv
// regwr_scoreboard: registered one-hot write decode, pending-write scoreboard and RAW hazard detect
module regwr_scoreboard #(
   parameter int ADDR_W  = 5,
   parameter bit ZERO_EN = 1'b1
) (
   input logic               clk,
   input logic               reset_n,
   regwr_scoreboard_if.slave bus
);
   localparam int NREG = 2**ADDR_W;
   logic [NREG-1:0] onehot_q, onehot_d, busy_q, busy_d, set_vec;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic            wr_eff, iss_eff, inc, dec;
   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_EN && (&a);
   endfunction
   // count moves by at most one up and one down per edge, so no popcount is needed
   always_comb begin
      wr_eff   = bus.wr_en && !is_zero(bus.wr_addr);
      iss_eff  = bus.iss_valid && !is_zero(bus.iss_addr);
      onehot_d = wr_eff ? (NREG'(1) << bus.wr_addr) : '0;
      set_vec  = iss_eff ? (NREG'(1) << bus.iss_addr) : '0;
      busy_d   = (busy_q & ~onehot_d) | set_vec;
      inc      = iss_eff && !busy_q[bus.iss_addr];
      dec      = wr_eff && busy_q[bus.wr_addr] && !(iss_eff && bus.iss_addr == bus.wr_addr);
      cnt_d    = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         onehot_q <= '0;
         busy_q   <= '0;
         cnt_q    <= '0;
      end else begin
         onehot_q <= onehot_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end
   assign bus.wr_onehot = onehot_q;
   assign bus.busy      = busy_q;
   assign bus.pend_cnt  = cnt_q;
   assign bus.all_idle  = (cnt_q == '0);
   // a same-cycle writeback to the source forwards the value, so no stall
   assign bus.hazard_a  = busy_q[bus.rd_addr_a] && !is_zero(bus.rd_addr_a) &&
                          !(bus.wr_en && bus.wr_addr == bus.rd_addr_a);
   assign bus.hazard_b  = busy_q[bus.rd_addr_b] && !is_zero(bus.rd_addr_b) &&
                          !(bus.wr_en && bus.wr_addr == bus.rd_addr_b);
endmodule

// File: tb/tb_regwr_scoreboard.sv
// tb_regwr_scoreboard: vector table, directed corner sequences and random traffic against a set-based model
module tb_regwr_scoreboard;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   bit [31:0] m_busy = '0;
   typedef struct {
      bit          en;
      logic [4:0]  addr;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[40];
   regwr_scoreboard_if #(.ADDR_W(5)) a();
   regwr_scoreboard_if #(.ADDR_W(3)) b();
   regwr_scoreboard #(.ADDR_W(5), .ZERO_EN(1'b1)) u0 (.clk(clk), .reset_n(reset_n), .bus(a.slave));
   regwr_scoreboard #(.ADDR_W(3), .ZERO_EN(1'b0)) u1 (.clk(clk), .reset_n(reset_n), .bus(b.slave));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   function automatic bit exp_haz(input logic [4:0] r);
      return m_busy[r] && r != 5'd31 && !(a.wr_en && a.wr_addr == r);
   endfunction
   task automatic idle();
      a.wr_en = 0; a.iss_valid = 0;
   endtask
   // model: busy is a set of register numbers; count is its cardinality
   task automatic step();
      bit [31:0] nb, no;
      #1;
      chk("hazard_a", a.hazard_a, exp_haz(a.rd_addr_a));
      chk("hazard_b", a.hazard_b, exp_haz(a.rd_addr_b));
      nb = m_busy;
      no = '0;
      if (a.wr_en && a.wr_addr != 5'd31) begin
         no[a.wr_addr] = 1'b1;
         nb[a.wr_addr] = 1'b0;
      end
      if (a.iss_valid && a.iss_addr != 5'd31) nb[a.iss_addr] = 1'b1;
      @(posedge clk);
      #1;
      m_busy = nb;
      chk("wr_onehot", a.wr_onehot, no);
      chk("busy", a.busy, m_busy);
      chk("pend_cnt", a.pend_cnt, $countones(m_busy));
      chk("all_idle", a.all_idle, m_busy == 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      for (int n = 0; n < 32; n++) vecs[n] = '{1'b1, 5'(n), (n == 31) ? 32'h0 : (32'h1 << n)};
      for (int n = 32; n < 40; n++) vecs[n] = '{1'b0, 5'($urandom_range(0, 31)), 32'h0};
      idle();
      a.wr_addr = 0; a.iss_addr = 0; a.rd_addr_a = 0; a.rd_addr_b = 0;
      b.wr_en = 0; b.iss_valid = 0; b.wr_addr = 0; b.iss_addr = 0; b.rd_addr_a = 0; b.rd_addr_b = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", a.busy, 0);
      chk("rst_cnt", a.pend_cnt, 0);
      chk("rst_idle", a.all_idle, 1);
      chk("rst_onehot", a.wr_onehot, 0);
      reset_n = 1'b1;
      // reset mid-operation, with a write enable in flight
      a.iss_valid = 1; a.iss_addr = 3; step();
      a.iss_addr = 7; a.wr_en = 1; a.wr_addr = 4; a.rd_addr_a = 3; step();
      idle();
      #1;
      chk("pre_rst_haz", a.hazard_a, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_busy", a.busy, 0);
      chk("async_cnt", a.pend_cnt, 0);
      chk("async_onehot", a.wr_onehot, 0);
      chk("async_idle", a.all_idle, 1);
      chk("async_haz", a.hazard_a, 0);
      m_busy = '0;
      reset_n = 1'b1;
      // decode sweep from the vector table
      for (int i = 0; i < 40; i++) begin
         a.wr_en = vecs[i].en; a.wr_addr = vecs[i].addr;
         step();
         chk($sformatf("decode[%0d]", i), a.wr_onehot, vecs[i].exp);
      end
      idle();
      // hazard and same-cycle forward
      a.iss_valid = 1; a.iss_addr = 5; step();
      idle(); a.rd_addr_a = 5; a.rd_addr_b = 6;
      #1;
      chk("haz_x5", a.hazard_a, 1);
      chk("haz_x6", a.hazard_b, 0);
      a.wr_en = 1; a.wr_addr = 5;
      #1;
      chk("haz_fwd", a.hazard_a, 0);
      step();
      chk("fwd_busy5", a.busy[5], 0);
      chk("fwd_cnt", a.pend_cnt, 0);
      idle();
      // simultaneous issue and writeback, same register
      a.iss_valid = 1; a.iss_addr = 9; step();
      a.wr_en = 1; a.wr_addr = 9; step();
      chk("same_busy9", a.busy[9], 1);
      chk("same_cnt", a.pend_cnt, 1);
      a.iss_valid = 0; step();
      chk("clr_cnt", a.pend_cnt, 0);
      a.iss_valid = 1; step();
      chk("same_nb_busy9", a.busy[9], 1);
      chk("same_nb_cnt", a.pend_cnt, 1);
      a.iss_valid = 0; step();
      idle();
      // fill then drain with concurrent issues
      for (int i = 0; i < 32; i++) begin
         a.iss_valid = 1; a.iss_addr = 5'(i); a.rd_addr_a = 5'($urandom_range(0, 31)); step();
      end
      chk("fill_cnt", a.pend_cnt, 31);
      chk("fill_busy31", a.busy[31], 0);
      for (int i = 0; i < 32; i++) begin
         a.wr_en = 1; a.wr_addr = 5'(i);
         a.iss_addr = 5'($urandom_range(0, 31));
         a.rd_addr_a = 5'($urandom_range(0, 31)); a.rd_addr_b = 5'(i);
         step();
      end
      // random traffic
      for (int i = 0; i < 300; i++) begin
         a.wr_en = 1'($urandom); a.wr_addr = 5'($urandom);
         a.iss_valid = 1'($urandom); a.iss_addr = 5'($urandom);
         a.rd_addr_a = 5'($urandom); a.rd_addr_b = ($urandom_range(0, 3) == 0) ? a.wr_addr : 5'($urandom);
         step();
      end
      idle();
      // no zero register with ZERO_EN=0, ADDR_W=3
      b.iss_valid = 1; b.iss_addr = 7; step();
      chk("z0_busy", b.busy, 8'h80);
      chk("z0_cnt", b.pend_cnt, 1);
      b.iss_valid = 0; b.wr_en = 1; b.wr_addr = 7; step();
      chk("z0_onehot", b.wr_onehot, 8'h80);
      chk("z0_cnt_clr", b.pend_cnt, 0);
      chk("z0_idle", b.all_idle, 1);
      b.wr_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regwr_scoreboard.md
# regwr_scoreboard

Parametrised successor to the register-file write decoder for the LEGv8 pipeline. It turns a writeback destination into a registered one-hot write-enable vector, masking the zero register (XZR). It also tracks a per-register pending-write scoreboard, set at issue and cleared at writeback, and reports read-after-write hazards for two source operands. It sits between decode/issue and the register file and feeds the stall logic.

## Interface
- `ADDR_W`, 5, register address width; `NREG = 2**ADDR_W` is derived, not overridable
- `ZERO_EN`, 1, when 1, index `NREG-1` is the hard-wired zero register (never written, never busy)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  writeback valid this cycle
- `wr_addr`  in  ADDR_W  writeback destination
- `iss_valid`  in  1  instruction issuing with a destination this cycle
- `iss_addr`  in  ADDR_W  issuing destination
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  source operands being checked
- `wr_onehot`  out  NREG  registered one-hot write enables to the register file
- `busy`  out  NREG  registered pending-write bits
- `hazard_a`, `hazard_b`  out  1  combinational RAW hazard per source
- `pend_cnt`  out  ADDR_W+1  registered count of set `busy` bits
- `all_idle`  out  1  combinational, `pend_cnt == 0`

## Operation
- Zero-register masking applies when `ZERO_EN=1` and the address is `NREG-1`:
  - the write is "null" and produces no one-hot bit
  - the issue is ignored
  - the source never hazards
- Decode: each edge, `wr_onehot <= (wr_en && !null) ? (1 << wr_addr) : 0`.
  - At most one bit is set.
  - Output is all-zero whenever `wr_en=0`.
- Scoreboard set: an effective issue (`iss_valid && !zero`) sets `busy[iss_addr]` at the edge.
  - Issue to an already-busy register is legal: the bit stays 1 and `pend_cnt` is unchanged.
- Scoreboard clear: an effective writeback (`wr_en && !null`) clears `busy[wr_addr]` at the edge.
  - Writeback to a non-busy register is legal: `busy` and `pend_cnt` are unchanged, and `wr_onehot` is still produced.
- Simultaneous issue and writeback, same address: set wins and the bit stays 1.
  - `pend_cnt` stays unchanged if the bit was busy.
  - `pend_cnt` goes +1 if it was not busy.
- Simultaneous issue and writeback, different addresses: both apply in the same edge.
  - `pend_cnt` changes by (+1 if the issued bit was clear) plus (−1 if the written bit was set).
- `pend_cnt` invariant: equals popcount(`busy`) after every edge.
  - It is maintained incrementally, with no full popcount adder in the loop.
  - Maximum is `NREG-1` with `ZERO_EN=1`, else `NREG`. The width covers both.
- Hazard: `hazard_x = busy[rd_addr_x] && !zero(rd_addr_x) && !(wr_en && wr_addr == rd_addr_x)`.
  - A same-cycle writeback forwards and suppresses the hazard.
  - The same-cycle issue does not raise it; that is compared next cycle.

## Timing
- Reset (`reset_n` low, asynchronous, any time): `wr_onehot=0`, `busy=0`, `pend_cnt=0`, `all_idle=1`.
  - Hazards read 0.
  - Any in-flight write enable is dropped, not completed.
- Deassertion is sampled synchronously. The first functional edge is the first rising `clk` with `reset_n` high.
- Latency:
  - `wr_addr` → `wr_onehot`: 1 cycle.
  - issue → `busy`: 1 cycle.
  - writeback → `busy` clear: 1 cycle, the same edge that presents `wr_onehot`.
  - `rd_addr` → hazard: 0 cycles, combinational.
- No handshake back-pressure. Every input is consumed at each edge. Throughput is one issue plus one writeback per cycle.
- Out-of-range addresses are impossible: the width equals `ADDR_W`.

## Test plan
- Reset mid-operation:
  - Stimulus: issue X3, X7, then pulse `reset_n` low between edges.
  - Required: `busy=0` and `pend_cnt=0` immediately, with no clock needed; `wr_onehot=0`.
- Decode sweep, `ADDR_W=5`, `wr_en=1`, `wr_addr` 0..31:
  - `wr_onehot = 1<<n` one cycle later for n=0..30.
  - n=31 gives 0.
  - With `wr_en=0`, every value gives 0.
- Hazard and forward:
  - Issue X5, then present `rd_addr_a=5`: `hazard_a=1`.
  - Same cycle add `wr_en=1`, `wr_addr=5`: `hazard_a=0`.
  - Next cycle `busy[5]=0`, `pend_cnt=0`.
- Simultaneous same address:
  - X9 busy; issue and writeback X9 in the same cycle: `busy[9]` stays 1, `pend_cnt` stays 1.
  - Repeat with X9 not busy: `busy[9]=1`, `pend_cnt=1`.
- Fill and drain:
  - Issue X0..X31 on consecutive cycles: `pend_cnt` ends at 31 and `busy[31]=0`.
  - Write back all of them with a concurrent new issue each cycle: `pend_cnt` tracks popcount(`busy`) every cycle and ends at the expected value.
- `ZERO_EN=0`, `ADDR_W=3`:
  - Issue X7: `busy[7]=1`, `pend_cnt=1`.
  - Writeback X7: `wr_onehot=8'h80`, `pend_cnt=0`.
